pipe_ctrl: RTL and testbench

- Pipelined successor to the single-cycle RV32I controller, for the 5-stage core (IF/ID/EX/MEM/WB).
- Decodes in ID and carries control fields through the ID/EX, EX/MEM and MEM/WB control registers.
- Resolves branches and jumps in EX, and detects load-use hazards.
- Produces forwarding selects and handles an external memory stall.

---
 rtl/pipe_ctrl_pkg.sv | 80 ++++++++
 rtl/pipe_ctrl_decode.sv | 107 ++++++++++
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared control types for the 5-stage RV32I pipeline controller.
// Opcodes, ALU/immediate/writeback encodings and the per-stage ctrl_t bundle.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_e    alu_sel;
    logic       asel;
    logic       bsel;
    logic       br_un;
    logic       is_branch;
    logic       is_jump;
    logic       is_load;
    logic       mem_rw;
    logic [2:0] funct3;
    wb_sel_e    wb_sel;
    logic       wen;
  } ctrl_t;

  function automatic alu_op_e alu_of(
    input logic       r_type,
    input logic [2:0] f3,
    input logic       b30
  );
    alu_op_e op;
    case (f3)
      3'd0:    op = (r_type && b30) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational RV32I instruction -> ctrl_t decoder.
// Unused source fields read as x0 so hazard compares need no format check.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic        i_valid,
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output imm_sel_e    o_imm_sel
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_use1;
  logic       w_use2;
  logic       w_known;
  logic       w_unused;

  assign w_op     = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_unused = ^{i_instr[31], i_instr[29:25]};

  always_comb begin
    o_ctrl    = '0;
    o_imm_sel = IMM_I;
    w_use1    = 1'b1;
    w_use2    = 1'b0;
    w_known   = 1'b1;
    unique case (1'b1)
      w_op == OP_R: begin
        w_use2         = 1'b1;
        o_ctrl.wen     = 1'b1;
        o_ctrl.wb_sel  = WB_ALU;
        o_ctrl.alu_sel = alu_of(1'b1, w_f3, i_instr[30]);
      end
      w_op == OP_I: begin
        o_ctrl.wen     = 1'b1;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.wb_sel  = WB_ALU;
        o_ctrl.alu_sel = alu_of(1'b0, w_f3, i_instr[30]);
      end
      w_op == OP_LOAD: begin
        o_ctrl.wen     = 1'b1;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.is_load = 1'b1;
      end
      w_op == OP_STORE: begin
        w_use2        = 1'b1;
        o_ctrl.bsel   = 1'b1;
        o_ctrl.mem_rw = 1'b1;
        o_imm_sel     = IMM_S;
      end
      w_op == OP_BRANCH: begin
        w_use2           = 1'b1;
        o_ctrl.asel      = 1'b1;
        o_ctrl.bsel      = 1'b1;
        o_ctrl.is_branch = 1'b1;
        o_ctrl.br_un     = w_f3[1];
        o_imm_sel        = IMM_B;
      end
      w_op == OP_JAL: begin
        w_use1         = 1'b0;
        o_ctrl.wen     = 1'b1;
        o_ctrl.asel    = 1'b1;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.is_jump = 1'b1;
        o_ctrl.wb_sel  = WB_PC4;
        o_imm_sel      = IMM_J;
      end
      w_op == OP_JALR: begin
        o_ctrl.wen     = 1'b1;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.is_jump = 1'b1;
        o_ctrl.wb_sel  = WB_PC4;
      end
      w_op == OP_LUI: begin
        w_use1         = 1'b0;
        o_ctrl.wen     = 1'b1;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.alu_sel = ALU_PASSB;
        o_ctrl.wb_sel  = WB_ALU;
        o_imm_sel      = IMM_U;
      end
      w_op == OP_AUIPC: begin
        w_use1        = 1'b0;
        o_ctrl.wen    = 1'b1;
        o_ctrl.asel   = 1'b1;
        o_ctrl.bsel   = 1'b1;
        o_ctrl.wb_sel = WB_ALU;
        o_imm_sel     = IMM_U;
      end
      default: w_known = 1'b0;
    endcase
    o_ctrl.valid  = 1'b1;
    o_ctrl.funct3 = w_f3;
    o_ctrl.rs1    = w_use1 ? i_instr[19:15] : '0;
    o_ctrl.rs2    = w_use2 ? i_instr[24:20] : '0;
    o_ctrl.rd     = i_instr[11:7];
    if (o_ctrl.rd == '0) o_ctrl.wen = 1'b0;
    if (!o_ctrl.wen) o_ctrl.rd = '0;
    if (!(i_valid && w_known)) begin
      o_ctrl    = '0;
      o_imm_sel = IMM_I;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline controller: ID decode, ID/EX/MEM/WB control registers,
// EX branch resolution, load-use / RAW interlock and operand forwarding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ALU_W      = 4,
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic                  stall_ext,
  input  logic                  ex_br_eq,
  input  logic                  ex_br_lt,
  output logic                  if_stall,
  output logic                  ifid_flush,
  output logic                  pc_sel,
  output logic [2:0]            id_imm_sel,
  output logic [ALU_W-1:0]      ex_alu_sel,
  output logic                  ex_asel,
  output logic                  ex_bsel,
  output logic                  ex_br_un,
  output logic [1:0]            ex_fwd_a,
  output logic [1:0]            ex_fwd_b,
  output logic                  mem_rw,
  output logic [2:0]            mem_funct3,
  output logic [1:0]            wb_sel,
  output logic                  wb_wen,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  ctrl_t    w_id;
  ctrl_t    r_ex;
  ctrl_t    r_mem;
  ctrl_t    r_wb;
  imm_sel_e w_imm;
  logic     w_cond;
  logic     w_taken;
  logic     w_ld_use;
  logic     w_raw;
  logic     w_hazard;
  logic     w_unused;

  pipe_ctrl_decode u_dec (
    .i_valid   (id_valid),
    .i_instr   (id_instr),
    .o_ctrl    (w_id),
    .o_imm_sel (w_imm)
  );

  function automatic logic hit(input ctrl_t c, input logic [4:0] rs);
    return c.valid && c.wen && (c.rd != '0) && (c.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_of(
    input ctrl_t      m,
    input ctrl_t      w,
    input logic [4:0] rs
  );
    if (hit(m, rs)) return 2'd1;
    if (hit(w, rs)) return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    case (r_ex.funct3)
      3'b000:         w_cond = ex_br_eq;
      3'b001:         w_cond = !ex_br_eq;
      3'b100, 3'b110: w_cond = ex_br_lt;
      3'b101, 3'b111: w_cond = !ex_br_lt;
      default:        w_cond = 1'b0;
    endcase
  end

  assign w_taken = r_ex.valid &&
    (r_ex.is_jump || (r_ex.is_branch && w_cond));

  assign w_ld_use = w_id.valid && r_ex.is_load &&
    (hit(r_ex, w_id.rs1) || hit(r_ex, w_id.rs2));

  // Without forwarding, any older EX/MEM writer must reach WB first
  assign w_raw = !FWD_EN && w_id.valid &&
    (hit(r_ex, w_id.rs1) || hit(r_ex, w_id.rs2) ||
     hit(r_mem, w_id.rs1) || hit(r_mem, w_id.rs2));

  assign w_hazard = w_ld_use || w_raw;

  assign pc_sel     = w_taken && !stall_ext;
  assign ifid_flush = w_taken && !stall_ext;
  assign if_stall   = stall_ext || (w_hazard && !w_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!stall_ext) begin
      r_ex  <= (w_taken || w_hazard) ? '0 : w_id;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign id_imm_sel = w_imm;
  assign ex_alu_sel = ALU_W'(r_ex.alu_sel);
  assign ex_asel    = r_ex.asel;
  assign ex_bsel    = r_ex.bsel;
  assign ex_br_un   = r_ex.br_un;
  assign ex_fwd_a   = FWD_EN ? fwd_of(r_mem, r_wb, r_ex.rs1) : 2'd0;
  assign ex_fwd_b   = FWD_EN ? fwd_of(r_mem, r_wb, r_ex.rs2) : 2'd0;
  assign mem_rw     = r_mem.mem_rw;
  assign mem_funct3 = (r_mem.is_load || r_mem.mem_rw) ?
    r_mem.funct3 : 3'd0;
  assign wb_sel     = r_wb.wb_sel;
  assign wb_wen     = r_wb.wen;
  assign wb_rd      = REG_ADDR_W'(r_wb.rd);

  assign w_unused = ^{r_ex, r_mem, r_wb};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: stage-occupancy reference model plus directed
// sequences with literal expectations and a randomized instruction stream.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        id_valid = 1'b0, stall_ext = 1'b0;
  logic        ex_br_eq = 1'b0, ex_br_lt = 1'b0;
  logic [31:0] id_instr = '0;
  logic        if_stall, ifid_flush, pc_sel;
  logic [2:0]  id_imm_sel, mem_funct3;
  logic [3:0]  ex_alu_sel;
  logic        ex_asel, ex_bsel, ex_br_un, mem_rw, wb_wen;
  logic [1:0]  ex_fwd_a, ex_fwd_b, wb_sel;
  logic [4:0]  wb_rd;

  logic        d2_valid = 1'b0;
  logic [31:0] d2_instr = '0;
  logic        d2_if_stall, d2_ifid_flush, d2_pc_sel;
  logic [2:0]  d2_imm_sel, d2_mem_funct3;
  logic [3:0]  d2_alu_sel;
  logic        d2_asel, d2_bsel, d2_br_un, d2_mem_rw, d2_wb_wen;
  logic [1:0]  d2_fwd_a, d2_fwd_b, d2_wb_sel;
  logic [4:0]  d2_wb_rd;

  pipe_ctrl #(.ALU_W(4), .REG_ADDR_W(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .stall_ext(stall_ext), .ex_br_eq(ex_br_eq), .ex_br_lt(ex_br_lt),
    .if_stall(if_stall), .ifid_flush(ifid_flush), .pc_sel(pc_sel),
    .id_imm_sel(id_imm_sel), .ex_alu_sel(ex_alu_sel), .ex_asel(ex_asel),
    .ex_bsel(ex_bsel), .ex_br_un(ex_br_un), .ex_fwd_a(ex_fwd_a),
    .ex_fwd_b(ex_fwd_b), .mem_rw(mem_rw), .mem_funct3(mem_funct3),
    .wb_sel(wb_sel), .wb_wen(wb_wen), .wb_rd(wb_rd)
  );

  pipe_ctrl #(.ALU_W(4), .REG_ADDR_W(5), .FWD_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(d2_valid), .id_instr(d2_instr),
    .stall_ext(1'b0), .ex_br_eq(1'b0), .ex_br_lt(1'b0),
    .if_stall(d2_if_stall), .ifid_flush(d2_ifid_flush),
    .pc_sel(d2_pc_sel), .id_imm_sel(d2_imm_sel), .ex_alu_sel(d2_alu_sel),
    .ex_asel(d2_asel), .ex_bsel(d2_bsel), .ex_br_un(d2_br_un),
    .ex_fwd_a(d2_fwd_a), .ex_fwd_b(d2_fwd_b), .mem_rw(d2_mem_rw),
    .mem_funct3(d2_mem_funct3), .wb_sel(d2_wb_sel), .wb_wen(d2_wb_wen),
    .wb_rd(d2_wb_rd)
  );

  typedef struct packed {
    logic       v, wen, ld, st, br, jp;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3, imm;
    logic [3:0] alu;
    logic       asel, bsel, brun;
    logic [1:0] wbs;
  } rec_t;

  rec_t m_ex, m_mem, m_wb;
  logic hold = 1'b0, redir = 1'b0;
  int   checks = 0, errors = 0;

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] aluf(logic r, logic [2:0] f, logic b);
    logic [3:0] t[8];
    t = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f == 3'd0 && r && b) return 4'd1;
    if (f == 3'd5 && b) return 4'd7;
    return t[f];
  endfunction

  function automatic rec_t dec(logic [31:0] x, logic v);
    rec_t r;
    logic u1, u2;
    r = '0; u1 = 1'b1; u2 = 1'b0;
    if (!v) return r;
    r.bsel = 1'b1;
    case (x[6:0])
      7'h33: begin u2 = 1; r.wen = 1; r.bsel = 0; r.alu = aluf(1, x[14:12], x[30]); end
      7'h13: begin r.wen = 1; r.alu = aluf(0, x[14:12], x[30]); end
      7'h03: begin r.wen = 1; r.ld = 1; end
      7'h23: begin u2 = 1; r.st = 1; r.imm = 1; end
      7'h63: begin u2 = 1; r.br = 1; r.asel = 1; r.imm = 2; r.brun = x[13]; end
      7'h6f: begin u1 = 0; r.wen = 1; r.jp = 1; r.asel = 1; r.imm = 4; end
      7'h67: begin r.wen = 1; r.jp = 1; end
      7'h37: begin u1 = 0; r.wen = 1; r.alu = 4'd10; r.imm = 3; end
      7'h17: begin u1 = 0; r.wen = 1; r.asel = 1; r.imm = 3; end
      default: return '0;
    endcase
    r.v   = 1'b1;
    r.f3  = x[14:12];
    r.rd  = x[11:7];
    r.rs1 = u1 ? x[19:15] : 5'd0;
    r.rs2 = u2 ? x[24:20] : 5'd0;
    if (r.rd == 0) r.wen = 1'b0;
    r.wbs = r.ld ? 2'd0 : (r.jp ? 2'd2 : 2'd1);
    return r;
  endfunction

  function automatic logic cond(logic [2:0] f, logic eq, logic lt);
    case (f)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int fwd(logic [4:0] rs);
    if (m_mem.wen && m_mem.rd == rs) return 1;
    if (m_wb.wen && m_wb.rd == rs) return 2;
    return 0;
  endfunction

  // Compare every output against the model, then advance one clock
  task automatic tick();
    rec_t id;
    logic tk, lu, st;
    id = dec(id_instr, id_valid);
    st = stall_ext;
    tk = m_ex.v && (m_ex.jp || (m_ex.br && cond(m_ex.f3, ex_br_eq, ex_br_lt)));
    lu = m_ex.ld && m_ex.wen && id.v &&
         (id.rs1 == m_ex.rd || id.rs2 == m_ex.rd);
    chk("if_stall", if_stall, st || (lu && !tk));
    chk("pc_sel", pc_sel, tk && !st);
    chk("ifid_flush", ifid_flush, tk && !st);
    chk("id_imm_sel", id_imm_sel, id.imm);
    chk("ex_alu_sel", ex_alu_sel, m_ex.alu);
    chk("ex_asel", ex_asel, m_ex.asel);
    chk("ex_bsel", ex_bsel, m_ex.bsel);
    chk("ex_br_un", ex_br_un, m_ex.brun);
    chk("ex_fwd_a", ex_fwd_a, fwd(m_ex.rs1));
    chk("ex_fwd_b", ex_fwd_b, fwd(m_ex.rs2));
    chk("mem_rw", mem_rw, m_mem.st);
    if (m_mem.ld || m_mem.st) chk("mem_funct3", mem_funct3, m_mem.f3);
    chk("wb_wen", wb_wen, m_wb.wen);
    if (m_wb.wen) chk("wb_rd", wb_rd, m_wb.rd);
    if (m_wb.wen) chk("wb_sel", wb_sel, m_wb.wbs);
    hold  = st || (lu && !tk);
    redir = tk && !st;
    @(posedge clk);
    if (!st) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (tk || lu) ? rec_t'('0) : id;
    end
    @(negedge clk);
  endtask

  task automatic set_in(logic [31:0] i, logic v, logic s, logic e, logic l);
    id_instr = i; id_valid = v; stall_ext = s; ex_br_eq = e; ex_br_lt = l;
    #1;
  endtask

  task automatic bub(int n);
    repeat (n) begin set_in(32'h0, 0, 0, 0, 0); tick(); end
  endtask

  task automatic lit_zero(string n);
    chk(n, int'({if_stall, ifid_flush, pc_sel, id_imm_sel, ex_alu_sel,
      ex_asel, ex_bsel, ex_br_un, ex_fwd_a, ex_fwd_b, mem_rw, mem_funct3,
      wb_sel, wb_wen, wb_rd}), 0);
  endtask

  function automatic logic [31:0] enc_r(logic b, logic [4:0] s2, s1,
                                        logic [2:0] f, logic [4:0] d);
    return {1'b0, b, 5'd0, s2, s1, f, d, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] s1,
                                        logic [2:0] f, logic [4:0] d,
                                        logic [6:0] op);
    return {im, s1, f, d, op};
  endfunction
  function automatic logic [31:0] enc_sb(logic [4:0] s2, s1,
                                         logic [2:0] f, logic [6:0] op);
    return {7'd0, s2, s1, f, 5'd0, op};
  endfunction
  function automatic logic [31:0] enc_u(logic [4:0] d, logic [6:0] op);
    return {20'h12345, d, op};
  endfunction

  function automatic logic [31:0] rnd();
    int k;
    logic [4:0] a, b, d;
    logic [2:0] f;
    logic [2:0] bf[6];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    k = $urandom_range(0, 9);
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    f = 3'($urandom_range(0, 7));
    case (k)
      0: return enc_r(1'($urandom_range(0, 1)), b, a, f, d);
      1: return enc_i(12'($urandom), a, f, d, 7'h13);
      2: return enc_i(12'($urandom), a, f, d, 7'h03);
      3: return enc_sb(b, a, f, 7'h23);
      4: return enc_sb(b, a, bf[$urandom_range(0, 5)], 7'h63);
      5: return enc_u(d, 7'h6f);
      6: return enc_i(12'($urandom), a, 3'd0, d, 7'h67);
      7: return enc_u(d, 7'h37);
      8: return enc_u(d, 7'h17);
      default: return {25'($urandom), 7'h7f};
    endcase
  endfunction

  logic [31:0] ADDI1, ADD3, NOP, LW, SUB, BEQ, ADDI5, BLTU, JAL1, cur_i;
  logic cur_v;

  initial begin
    ADDI1 = enc_i(12'd6, 5'd0, 3'd0, 5'd1, 7'h13);
    ADD3  = enc_r(1'b0, 5'd1, 5'd1, 3'd0, 5'd3);
    NOP   = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
    LW    = enc_i(12'd0, 5'd30, 3'd2, 5'd6, 7'h03);
    SUB   = enc_r(1'b1, 5'd6, 5'd1, 3'd0, 5'd3);
    BEQ   = enc_sb(5'd2, 5'd1, 3'd0, 7'h63);
    ADDI5 = enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'h13);
    BLTU  = enc_sb(5'd2, 5'd1, 3'd6, 7'h63);
    JAL1  = enc_u(5'd1, 7'h6f);
    m_ex = '0; m_mem = '0; m_wb = '0;

    set_in(32'h0, 0, 0, 0, 0);
    lit_zero("reset_zero");
    tick();
    rst_n = 1'b1;
    set_in(32'h0, 0, 0, 0, 0);
    lit_zero("post_reset_zero");
    tick();

    set_in(ADDI1, 1, 0, 0, 0); tick();
    set_in(ADD3, 1, 0, 0, 0); tick();
    set_in(32'h0, 0, 0, 0, 0);
    chk("fwd_a_mem", ex_fwd_a, 1);
    chk("fwd_b_mem", ex_fwd_b, 1);
    tick(); bub(3);

    set_in(ADDI1, 1, 0, 0, 0); tick();
    set_in(NOP, 1, 0, 0, 0); tick();
    set_in(ADD3, 1, 0, 0, 0); tick();
    set_in(32'h0, 0, 0, 0, 0);
    chk("fwd_a_wb", ex_fwd_a, 2);
    chk("fwd_b_wb", ex_fwd_b, 2);
    tick(); bub(3);

    set_in(LW, 1, 0, 0, 0); tick();
    set_in(SUB, 1, 0, 0, 0);
    chk("lu_stall", if_stall, 1);
    tick();
    set_in(SUB, 1, 0, 0, 0);
    chk("lu_release", if_stall, 0);
    chk("lu_bubble_alu", ex_alu_sel, 0);
    chk("lu_bubble_bsel", ex_bsel, 0);
    tick();
    set_in(32'h0, 0, 0, 0, 0);
    chk("lu_sub_alu", ex_alu_sel, 1);
    chk("lu_fwd_b", ex_fwd_b, 2);
    tick(); bub(3);

    set_in(BEQ, 1, 0, 0, 0); tick();
    set_in(ADDI5, 1, 0, 1, 0);
    chk("beq_pc_sel", pc_sel, 1);
    chk("beq_flush", ifid_flush, 1);
    tick();
    set_in(32'h0, 0, 0, 0, 0);
    chk("beq_pc_sel_once", pc_sel, 0);
    tick(); bub(1);
    set_in(32'h0, 0, 0, 0, 0);
    chk("beq_squash1", wb_wen, 0);
    tick();
    set_in(32'h0, 0, 0, 0, 0);
    chk("beq_squash2", wb_wen, 0);
    tick(); bub(2);

    set_in(BEQ, 1, 0, 0, 0); tick();
    set_in(ADDI5, 1, 0, 0, 0);
    chk("beq_nt_pc_sel", pc_sel, 0);
    tick(); bub(2);
    set_in(32'h0, 0, 0, 0, 0);
    chk("beq_nt_wen", wb_wen, 1);
    tick(); bub(2);

    set_in(BLTU, 1, 0, 0, 0); tick();
    set_in(32'h0, 0, 0, 0, 1);
    chk("bltu_br_un", ex_br_un, 1);
    chk("bltu_pc_sel", pc_sel, 1);
    tick(); bub(3);

    set_in(JAL1, 1, 0, 0, 0); tick();
    bub(2);
    set_in(32'h0, 0, 0, 0, 0);
    chk("jal_wb_sel", wb_sel, 2);
    chk("jal_wb_wen", wb_wen, 1);
    chk("jal_wb_rd", wb_rd, 1);
    tick(); bub(2);

    set_in(BEQ, 1, 0, 0, 0); tick();
    repeat (3) begin
      set_in(ADDI5, 1, 1, 1, 0);
      chk("sx_pc_sel", pc_sel, 0);
      chk("sx_if_stall", if_stall, 1);
      chk("sx_frozen_asel", ex_asel, 1);
      tick();
    end
    set_in(ADDI5, 1, 0, 1, 0);
    chk("sx_release_pc_sel", pc_sel, 1);
    tick(); bub(3);

    d2_instr = ADDI1; d2_valid = 1; bub(1);
    d2_instr = ADD3;
    set_in(32'h0, 0, 0, 0, 0);
    chk("nofwd_stall1", d2_if_stall, 1); tick();
    set_in(32'h0, 0, 0, 0, 0);
    chk("nofwd_stall2", d2_if_stall, 1); tick();
    set_in(32'h0, 0, 0, 0, 0);
    chk("nofwd_go", d2_if_stall, 0); tick();
    d2_valid = 0;
    set_in(32'h0, 0, 0, 0, 0);
    chk("nofwd_fwd_a", d2_fwd_a, 0);
    chk("nofwd_add_ex", d2_bsel, 0);
    tick();

    set_in(ADDI1, 1, 0, 0, 0); tick();
    set_in(LW, 1, 0, 0, 0); tick();
    set_in(ADD3, 1, 0, 0, 0); tick();
    rst_n = 1'b0;
    set_in(32'h0, 0, 0, 0, 0);
    lit_zero("mid_reset_zero");
    m_ex = '0; m_mem = '0; m_wb = '0;
    tick();
    rst_n = 1'b1;
    set_in(32'h0, 0, 0, 0, 0);
    lit_zero("mid_reset_release");
    tick();

    cur_i = NOP; cur_v = 1'b0; hold = 1'b0; redir = 1'b0;
    repeat (3000) begin
      if (!hold) begin
        if (redir) cur_v = 1'b0;
        else begin
          cur_i = rnd();
          cur_v = ($urandom_range(0, 9) != 0);
        end
      end
      set_in(cur_i, cur_v, $urandom_range(0, 9) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
